// File: rtl/hydra_port_scheduler_if.sv
// hydra_port_scheduler_if: request/occupancy inputs and grant outputs of one read port's scheduler
interface hydra_port_scheduler_if #(parameter int PRIOR_NUM = 8);
    logic                 wrr_en;
    logic                 ready;
    logic [PRIOR_NUM-1:0] queue_nonempty;
    logic                 pkt_done;
    logic                 sel_vld;
    logic [2:0]           sel_prior;
    logic                 busy;
    modport master (output wrr_en, ready, queue_nonempty, pkt_done, input sel_vld, sel_prior, busy);
    modport slave  (input wrr_en, ready, queue_nonempty, pkt_done, output sel_vld, sel_prior, busy);
endinterface

// File: rtl/hydra_port_scheduler.sv
// hydra_port_scheduler: strict-priority / weighted-round-robin packet scheduler for one switch read port
module hydra_port_scheduler #(
    parameter int PRIOR_NUM = 8,
    parameter int CREDIT_W  = 4
) (
    input logic clk,
    input logic rst_n,
    hydra_port_scheduler_if.slave bus
);
    typedef enum logic {IDLE, SERVE} state_t;
    state_t state, state_nxt;
    logic req_q, grant, reload;
    logic [PRIOR_NUM-1:0] eligible;
    logic [2:0] hi_nonempty, hi_eligible, choice;
    logic [CREDIT_W-1:0] credit [PRIOR_NUM];

    always_comb begin
        hi_nonempty = '0;
        hi_eligible = '0;
        for (int p = 0; p < PRIOR_NUM; p++) begin
            eligible[p] = bus.queue_nonempty[p] && credit[p] != '0;
            if (bus.queue_nonempty[p]) hi_nonempty = 3'(p);
            if (eligible[p]) hi_eligible = 3'(p);
        end
    end

    // with no eligible credit left, WRR reloads and serves the top nonempty queue
    assign reload = bus.wrr_en && eligible == '0;
    assign choice = (bus.wrr_en && |eligible) ? hi_eligible : hi_nonempty;
    assign grant  = state == IDLE && (bus.ready || req_q) && |bus.queue_nonempty;

    always_ff @(posedge clk)
        if (!rst_n) state <= IDLE;
        else state <= state_nxt;

    always_comb
        state_nxt = (state == IDLE) ? (grant ? SERVE : IDLE) : (bus.pkt_done ? IDLE : SERVE);

    always_comb
        bus.busy = state == SERVE;

    always_ff @(posedge clk)
        if (!rst_n) begin
            bus.sel_vld   <= 1'b0;
            bus.sel_prior <= '0;
            req_q         <= 1'b0;
        end else begin
            bus.sel_vld <= grant;
            if (grant) bus.sel_prior <= choice;
            req_q <= !grant && (bus.ready || req_q);
        end

    always_ff @(posedge clk)
        for (int p = 0; p < PRIOR_NUM; p++)
            if (!rst_n) credit[p] <= CREDIT_W'(p + 1);
            else if (grant && bus.wrr_en)
                credit[p] <= reload ? CREDIT_W'(p + 1) - CREDIT_W'(3'(p) == choice)
                                    : credit[p] - CREDIT_W'(3'(p) == choice);
endmodule

// File: tb/tb_hydra_port_scheduler.sv
// tb_hydra_port_scheduler: directed checks of grant latency, strict/WRR choice, request latching and reset
module tb_hydra_port_scheduler;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;

    hydra_port_scheduler_if #(.PRIOR_NUM(8)) bus();
    hydra_port_scheduler dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    // one full ready -> grant -> pkt_done round trip
    task automatic serve(input string tag, input logic [2:0] exp);
        bus.ready = 1'b1;
        step();
        bus.ready = 1'b0;
        check({tag, "_vld"}, 32'(bus.sel_vld), 1);
        check({tag, "_prior"}, 32'(bus.sel_prior), 32'(exp));
        check({tag, "_busy"}, 32'(bus.busy), 1);
        step();
        check({tag, "_vld_pulse"}, 32'(bus.sel_vld), 0);
        bus.pkt_done = 1'b1;
        step();
        bus.pkt_done = 1'b0;
        check({tag, "_idle"}, 32'(bus.busy), 0);
    endtask

    initial begin
        bus.wrr_en = 1'b0;
        bus.ready = 1'b0;
        bus.pkt_done = 1'b0;
        bus.queue_nonempty = '0;
        do_reset();
        check("rst_vld", 32'(bus.sel_vld), 0);
        check("rst_prior", 32'(bus.sel_prior), 0);
        check("rst_busy", 32'(bus.busy), 0);

        // reset mid-SERVE
        bus.queue_nonempty = 8'h08;
        bus.ready = 1'b1;
        step();
        bus.ready = 1'b0;
        check("pre_rst_prior", 32'(bus.sel_prior), 3);
        do_reset();
        check("midrst_vld", 32'(bus.sel_vld), 0);
        check("midrst_prior", 32'(bus.sel_prior), 0);
        check("midrst_busy", 32'(bus.busy), 0);
        step();
        check("midrst_no_regrant", 32'(bus.sel_vld), 0);
        bus.wrr_en = 1'b1;
        bus.queue_nonempty = 8'hFF;
        serve("post_rst_wrr", 3'd7);

        // strict priority and simultaneous ready + pkt_done
        bus.wrr_en = 1'b0;
        bus.queue_nonempty = 8'b1010_0100;
        bus.ready = 1'b1;
        step();
        bus.ready = 1'b0;
        check("strict_vld", 32'(bus.sel_vld), 1);
        check("strict_prior", 32'(bus.sel_prior), 7);
        check("strict_busy", 32'(bus.busy), 1);
        step();
        bus.ready = 1'b1;
        bus.pkt_done = 1'b1;
        step();
        bus.ready = 1'b0;
        bus.pkt_done = 1'b0;
        check("strict_d1_busy", 32'(bus.busy), 0);
        check("strict_d1_vld", 32'(bus.sel_vld), 0);
        step();
        check("strict_d2_vld", 32'(bus.sel_vld), 1);
        check("strict_d2_prior", 32'(bus.sel_prior), 7);
        step();
        bus.pkt_done = 1'b1;
        step();
        bus.pkt_done = 1'b0;

        // WRR fairness over a full credit round plus reload
        do_reset();
        bus.wrr_en = 1'b1;
        bus.queue_nonempty = 8'hFF;
        for (int p = 7; p >= 0; p--)
            for (int k = 0; k <= p; k++)
                serve($sformatf("wrr_p%0d_%0d", p, k), 3'(p));
        serve("wrr_reload", 3'd7);

        // WRR skipping empty queues
        do_reset();
        bus.queue_nonempty = 8'h05;
        serve("skip_a", 3'd2);
        serve("skip_b", 3'd2);
        serve("skip_c", 3'd2);
        serve("skip_d", 3'd0);
        serve("skip_reload", 3'd2);

        // request held while nothing is queued
        bus.wrr_en = 1'b0;
        bus.queue_nonempty = '0;
        bus.ready = 1'b1;
        step();
        bus.ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("empty_hold_%0d", i), 32'(bus.sel_vld), 0);
            if (i < 4) step();
        end
        bus.queue_nonempty = 8'h04;
        step();
        check("empty_late_vld", 32'(bus.sel_vld), 1);
        check("empty_late_prior", 32'(bus.sel_prior), 2);
        step();
        bus.pkt_done = 1'b1;
        step();
        bus.pkt_done = 1'b0;

        // several ready pulses in SERVE collapse into one grant
        bus.queue_nonempty = 8'h10;
        bus.ready = 1'b1;
        step();
        bus.ready = 1'b0;
        check("bp_first_prior", 32'(bus.sel_prior), 4);
        for (int i = 0; i < 3; i++) begin
            bus.ready = 1'b1;
            step();
            bus.ready = 1'b0;
            step();
            check($sformatf("bp_serve_vld_%0d", i), 32'(bus.sel_vld), 0);
        end
        bus.pkt_done = 1'b1;
        step();
        bus.pkt_done = 1'b0;
        check("bp_done_busy", 32'(bus.busy), 0);
        step();
        check("bp_regrant_vld", 32'(bus.sel_vld), 1);
        check("bp_regrant_prior", 32'(bus.sel_prior), 4);
        step();
        bus.pkt_done = 1'b1;
        step();
        bus.pkt_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("bp_single_%0d", i), 32'(bus.sel_vld), 0);
        end
        bus.pkt_done = 1'b1;
        step();
        bus.pkt_done = 1'b0;
        check("idle_done_busy", 32'(bus.busy), 0);
        check("idle_done_vld", 32'(bus.sel_vld), 0);
        step();
        check("idle_done_after", 32'(bus.busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
